// File: rtl/sensor_poll_ctrl_if.sv
// Shared request/acknowledge sensor bus between the poll sequencer and the four
// ground-distance sensors.
interface sensor_poll_ctrl_if;
   logic       sen_req;
   logic [1:0] sen_sel;
   logic       sen_ack;
   logic [7:0] sen_data;

   modport master (output sen_req, output sen_sel, input sen_ack, input sen_data);
   modport slave  (input sen_req, input sen_sel, output sen_ack, output sen_data);
endinterface

// File: rtl/sensor_poll_ctrl.sv
// Polls four ground-distance sensors over one request/ack bus and fuses the
// readings into a single height value with a one-cycle valid strobe.
module sensor_poll_ctrl #(
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned AUTO_PERIOD = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   sensor_poll_ctrl_if.master         bus,
   output logic [7:0]                 height,
   output logic                       height_valid,
   output logic [3:0]                 timeout_mask
);

   localparam int unsigned DW = 8;
   localparam int unsigned SW = 10;
   localparam int unsigned WW = 8;
   localparam int unsigned PW = (AUTO_PERIOD > 0) ? $clog2(AUTO_PERIOD + 1) : 1;

   typedef enum logic [2:0] {IDLE, REQ, GAP, CALC, DONE} state_t;

   state_t               state;
   logic [3:0][DW-1:0]   slot;
   logic [WW-1:0]        wait_cnt;
   logic [3:0]           pend_mask;
   logic [PW-1:0]        period_cnt;

   logic                 auto_tick_c;
   logic                 trigger_c;
   logic                 timed_out_c;
   logic [SW-1:0]        sum_all_c;
   logic [SW-1:0]        sum_even_c;
   logic [SW-1:0]        sum_odd_c;
   logic [DW-1:0]        fuse_c;

   // Trigger decode and height fusion; a zero reading counts as a missing sensor.
   always_comb begin
      auto_tick_c = (AUTO_PERIOD != 0) && (period_cnt == PW'(AUTO_PERIOD));
      trigger_c   = start | auto_tick_c;
      timed_out_c = (wait_cnt == WW'(TIMEOUT - 1));
      sum_all_c   = SW'(slot[0]) + SW'(slot[1]) + SW'(slot[2]) + SW'(slot[3]) + SW'(2);
      sum_even_c  = SW'(slot[0]) + SW'(slot[2]) + SW'(1);
      sum_odd_c   = SW'(slot[1]) + SW'(slot[3]) + SW'(1);
      fuse_c      = '0;
      if ((slot[0] != '0) && (slot[1] != '0) && (slot[2] != '0) && (slot[3] != '0))
         fuse_c = DW'(sum_all_c >> 2);
      else if ((slot[0] == '0) || (slot[2] == '0))
         fuse_c = DW'(sum_odd_c >> 1);
      else
         fuse_c = DW'(sum_even_c >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         slot         <= '0;
         wait_cnt     <= '0;
         pend_mask    <= '0;
         period_cnt   <= '0;
         busy         <= 1'b0;
         bus.sen_req  <= 1'b0;
         bus.sen_sel  <= '0;
         height       <= '0;
         height_valid <= 1'b0;
         timeout_mask <= '0;
      end else begin
         height_valid <= 1'b0;
         case (state)
            IDLE: begin
               // Period counter only advances while idle and restarts on any trigger.
               if (trigger_c || (AUTO_PERIOD == 0))
                  period_cnt <= '0;
               else
                  period_cnt <= period_cnt + PW'(1);
               if (trigger_c) begin
                  state       <= REQ;
                  busy        <= 1'b1;
                  bus.sen_req <= 1'b1;
                  bus.sen_sel <= '0;
                  wait_cnt    <= '0;
                  pend_mask   <= '0;
               end
            end
            REQ: begin
               // Ack beats a simultaneous timeout.
               if (bus.sen_ack || timed_out_c) begin
                  if (bus.sen_ack) begin
                     slot[bus.sen_sel] <= bus.sen_data;
                  end else begin
                     slot[bus.sen_sel]      <= '0;
                     pend_mask[bus.sen_sel] <= 1'b1;
                  end
                  bus.sen_req <= 1'b0;
                  state       <= (bus.sen_sel == 2'd3) ? CALC : GAP;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            GAP: begin
               bus.sen_sel <= bus.sen_sel + 2'd1;
               wait_cnt    <= '0;
               bus.sen_req <= 1'b1;
               state       <= REQ;
            end
            CALC: begin
               height       <= fuse_c;
               timeout_mask <= pend_mask;
               height_valid <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy        <= 1'b0;
               bus.sen_req <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Bench for sensor_poll_ctrl: directed table, hand sequences for reset/start
// corner cases, randomized acquisitions against a reference model, auto-trigger.
module tb_sensor_poll_ctrl;

   localparam int unsigned TO = 4;

   logic       clk = 1'b0;
   logic       rst_n, start, busy, height_valid;
   logic [7:0] height;
   logic [3:0] timeout_mask;

   logic       rst_n_b, start_b, busy_b, height_valid_b;
   logic [7:0] height_b;
   logic [3:0] timeout_mask_b;

   always #5 clk = ~clk;

   sensor_poll_ctrl_if bus ();
   sensor_poll_ctrl_if bus_b ();

   sensor_poll_ctrl #(.TIMEOUT(TO), .AUTO_PERIOD(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .bus(bus),
      .height(height), .height_valid(height_valid), .timeout_mask(timeout_mask));

   sensor_poll_ctrl #(.TIMEOUT(16), .AUTO_PERIOD(20)) dut_auto (
      .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b), .bus(bus_b),
      .height(height_b), .height_valid(height_valid_b), .timeout_mask(timeout_mask_b));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0][7:0] v;
      logic [3:0][7:0] dly;
      int              eh;
      int              em;
      int              el;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: a sensor with delay d (0 = never) answers on its d-th request
   // cycle unless d exceeds TO, in which case it costs TO cycles and reads 0.
   function automatic void model(input logic [3:0][7:0] v, input logic [3:0][7:0] dly,
                                 output int h, output int mask, output int lat, output int c0);
      int s[4];
      int cyc[4];
      mask = 0;
      lat  = 3 + 1 + 1;
      for (int i = 0; i < 4; i++) begin
         if (dly[i] == 0 || int'(dly[i]) > int'(TO)) begin
            s[i] = 0; cyc[i] = TO; mask |= (1 << i);
         end else begin
            s[i] = v[i]; cyc[i] = dly[i];
         end
         lat += cyc[i];
      end
      c0 = cyc[0];
      if (s[0] != 0 && s[1] != 0 && s[2] != 0 && s[3] != 0)
         h = (s[0] + s[1] + s[2] + s[3] + 2) / 4;
      else if (s[0] == 0 || s[2] == 0)
         h = (s[1] + s[3] + 1) / 2;
      else
         h = (s[0] + s[2] + 1) / 2;
   endfunction

   // One acquisition with per-sensor ack delays; returns DUT results and latency.
   task automatic run_acq(input logic [3:0][7:0] v, input logic [3:0][7:0] dly,
                          output int h, output int mask, output int lat, output int c0);
      int cnt[4];
      bit got;
      got = 0; h = -1; mask = -1; lat = -1;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 200 && !got; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (height_valid) begin
            got = 1; h = height; mask = timeout_mask; lat = k;
            bus.sen_ack = 1'b0;
         end else if (bus.sen_req) begin
            cnt[bus.sen_sel]++;
            bus.sen_ack = (dly[bus.sen_sel] != 0) && (cnt[bus.sen_sel] == int'(dly[bus.sen_sel]));
            bus.sen_data = bus.sen_ack ? v[bus.sen_sel] : 8'($urandom);
         end else begin
            bus.sen_ack  = 1'b0;
            bus.sen_data = 8'($urandom);
         end
      end
      c0 = cnt[0];
      check("valid_seen", int'(got), 1);
      @(negedge clk);
      check("busy_after_done", int'(busy), 0);
   endtask

   // Auto-trigger instance: always-ready sensors, log every valid pulse.
   int vt_q[$];
   int vh_q[$];
   initial begin
      int cyc;
      cyc = 0;
      bus_b.sen_ack  = 1'b0;
      bus_b.sen_data = 8'd0;
      forever begin
         @(negedge clk);
         cyc++;
         if (height_valid_b) begin
            vt_q.push_back(cyc);
            vh_q.push_back(int'(height_b));
         end
         bus_b.sen_ack  = bus_b.sen_req;
         bus_b.sen_data = 8'd100 + 8'(bus_b.sen_sel);
      end
   end

   initial begin
      vec_t tbl[6];
      int h, m, l, c0, eh, em, el, ec0, nv;
      bit found;
      logic [3:0][7:0] rv, rd;

      tbl[0] = '{v: 32'h0D0C0B0A, dly: 32'h01010101, eh: 12,  em: 0,   el: 9};
      tbl[1] = '{v: 32'hFFFFFFFF, dly: 32'h01010101, eh: 255, em: 0,   el: 9};
      tbl[2] = '{v: 32'h08090763, dly: 32'h01010100, eh: 8,   em: 1,   el: 12};
      tbl[3] = '{v: 32'h1E28140A, dly: 32'h01040101, eh: 25,  em: 0,   el: 12};
      tbl[4] = '{v: 32'h1E190014, dly: 32'h01010101, eh: 23,  em: 0,   el: 9};
      tbl[5] = '{v: 32'h50463C32, dly: 32'h00010502, eh: 60,  em: 10,  el: 16};

      rst_n = 1'b0; rst_n_b = 1'b0; start = 1'b0; start_b = 1'b0;
      bus.sen_ack = 1'b0; bus.sen_data = 8'd0;
      repeat (2) @(negedge clk);
      check("reset_outputs", int'({busy, bus.sen_req, bus.sen_sel, height_valid, height, timeout_mask}), 0);
      rst_n = 1'b1; rst_n_b = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_acq(tbl[i].v, tbl[i].dly, h, m, l, c0);
         model(tbl[i].v, tbl[i].dly, eh, em, el, ec0);
         check($sformatf("tbl%0d_height", i), h, tbl[i].eh);
         check($sformatf("tbl%0d_mask", i), m, tbl[i].em);
         check($sformatf("tbl%0d_latency", i), l, tbl[i].el);
         check($sformatf("tbl%0d_req_cycles_sel0", i), c0, ec0);
      end

      // start while busy must be ignored: exactly one valid pulse.
      @(negedge clk);
      start = 1'b1;
      nv = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = (k == 3);
         if (height_valid) nv++;
         bus.sen_ack  = bus.sen_req;
         bus.sen_data = 8'd50;
      end
      check("start_while_busy_valids", nv, 1);
      check("start_while_busy_height", int'(height), 50);

      // Reset during the request to sensor index 2 aborts the acquisition.
      @(negedge clk);
      start = 1'b1;
      found = 0;
      for (int k = 1; k <= 50 && !found; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (bus.sen_req && bus.sen_sel == 2'd2) found = 1;
         else begin
            bus.sen_ack  = bus.sen_req;
            bus.sen_data = 8'd77;
         end
      end
      check("reach_sel2", int'(found), 1);
      bus.sen_ack = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", int'({busy, bus.sen_req, bus.sen_sel, height_valid, height, timeout_mask}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (height_valid) nv++;
         bus.sen_ack  = bus.sen_req;
         bus.sen_data = 8'd77;
      end
      check("midreset_no_valid", nv, 0);
      check("midreset_height", int'(height), 0);

      // Random acquisitions against the reference model.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 4; i++) begin
            rv[i] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            rd[i] = 8'($urandom_range(0, 6));
         end
         run_acq(rv, rd, h, m, l, c0);
         model(rv, rd, eh, em, el, ec0);
         check($sformatf("rnd%0d_height", n), h, eh);
         check($sformatf("rnd%0d_mask", n), m, em);
         check($sformatf("rnd%0d_latency", n), l, el);
         check($sformatf("rnd%0d_req_cycles_sel0", n), c0, ec0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Auto-trigger period: 20 idle cycles + 10-cycle acquisition.
      check("auto_pulse_count_ok", int'(vt_q.size() >= 3), 1);
      for (int i = 1; i < vt_q.size() && i < 6; i++)
         check($sformatf("auto_interval%0d", i), vt_q[i] - vt_q[i-1], 30);
      for (int i = 0; i < vh_q.size() && i < 6; i++)
         check($sformatf("auto_height%0d", i), vh_q[i], 102);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sensor_poll_ctrl.md
Name: sensor_poll_ctrl

Overview:
- Sequencer that polls the four helicopter ground-distance sensors over one shared request/acknowledge sensor bus.
- Captures the four 8-bit readings one at a time, converting a timed-out sensor to 0.
- Computes the fused height with the team's averaging and fallback rules, then presents it with a one-cycle valid strobe.
- Sits between the sensor bus interface and the altitude consumer logic.

Parameters:
- TIMEOUT, 16: max REQ cycles to wait for sen_ack per sensor; legal range 1..255.
- AUTO_PERIOD, 0: 0 = acquisitions only on start; N>0 = an internal trigger fires every N clocks while in IDLE.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  acquisition request, sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- sen_req  out  1  bus request to the sensor selected by sen_sel.
- sen_sel  out  2  sensor index 0..3 (sensor1..sensor4).
- sen_ack  in  1  sensor data valid; honoured only while sen_req=1.
- sen_data  in  8  sensor reading, captured when sen_req & sen_ack.
- height  out  8  last computed height, held until the next DONE.
- height_valid  out  1  one-cycle pulse when height updates.
- timeout_mask  out  4  bit i set = sensor i timed out in the last acquisition; updated at DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - height=0, height_valid=0, timeout_mask=0, sen_req=0, sen_sel=0, busy=0.
  - Capture registers, timeout counter and period counter cleared.
  - Reset mid-acquisition aborts it: no height_valid is produced and height stays 0.
- States: IDLE, REQ, GAP, CALC, DONE.
- IDLE:
  - Trigger = start | auto_tick.
  - On trigger: sen_sel=0 and go to REQ.
  - start while busy=1 is ignored, not queued.
  - start and auto_tick in the same cycle give one acquisition.
  - The period counter runs only in IDLE and restarts at 0 on each trigger.
- REQ:
  - sen_req=1.
  - If sen_ack=1, capture sen_data into slot sen_sel.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT, store 0 in the slot and set the pending mask bit.
  - If ack and timeout occur in the same cycle, ack wins and the mask bit stays clear.
  - After the slot is filled: go to GAP if sen_sel<3, else go to CALC.
- GAP:
  - sen_req=0 for exactly one cycle.
  - Increment sen_sel and clear the wait counter, then go to REQ.
- CALC: combinational fuse is registered into height_next. Use 10-bit sums.
  - All four readings nonzero: height = (s1+s2+s3+s4+2)>>2. This rounds remainder 2 and 3 up and remainder 1 down.
  - Else if s1==0 or s3==0: height = (s2+s4+1)>>1.
  - Else (s2==0 or s4==0): height = (s1+s3+1)>>1.
  - The result is always ≤255. No saturation logic is needed; truncate to 8 bits.
- DONE:
  - height and timeout_mask are updated; height_valid=1 for this single cycle.
  - Next state is IDLE.
- Latency, start sampled at cycle t with immediate acks:
  - REQ at t+1, t+3, t+5, t+7; GAP at t+2, t+4, t+6.
  - CALC at t+8.
  - DONE at t+9, with height_valid high during cycle t+9.
  - Each extra wait cycle on any sensor adds 1.
- A captured sen_data of 0 is treated identically to a timeout for the fuse, but the mask bit stays clear.
- busy deasserts in the cycle after DONE.

Test Plan:
- Immediate acks, data 10,11,12,13, start at t → height_valid at t+9, height=12 ((46+2)>>2), timeout_mask=0000.
- Data 255,255,255,255 → height=255 (1022>>2), no overflow.
- TIMEOUT=4, sensor1 never acks, s2=7, s3=9, s4=8 → sen_req held 4 cycles on sel 0, then moves on; height=8 ((15+1)>>1); timeout_mask=0001; valid at t+12.
- Ack on the same cycle the sensor3 timeout would fire, data 40 → slot keeps 40, mask bit2=0.
- Sensor2 returns data 0, s1=20, s3=25, s4=30 → height=23 ((45+1)>>1), timeout_mask=0000.
- Reset and start handling:
  - rst_n pulsed low during the REQ of sel 2 → all outputs 0 immediately, no height_valid afterwards.
  - start pulsed at t+3 during busy → ignored; exactly one valid.
  - AUTO_PERIOD=20 → valid pulses recur every 30 cycles with immediate acks.
